ex_stage: RTL and testbench



---
 rtl/ex_stage.sv | 141 ++++++++++++++
 tb/tb_ex_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: one-cycle ALU plus optional iterative shift-add MUL.
// Define EX_MUL_EN to build the multiplier; otherwise opcode 9 acts as undefined.
module ex_stage #(
  parameter int SIZE_DATA = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [3:0]           i_alu_op,
  input  logic [SIZE_DATA-1:0] i_rs_value,
  input  logic [SIZE_DATA-1:0] i_rt_value,
  input  logic [SIZE_DATA-1:0] i_rd,
  output logic                 o_valid,
  output logic [SIZE_DATA-1:0] o_result,
  output logic [SIZE_DATA-1:0] o_rd,
  output logic                 o_zero,
  output logic                 o_stall
);

  localparam int SH = $clog2(SIZE_DATA);

  logic [SIZE_DATA-1:0] a;
  logic [SIZE_DATA-1:0] b;
  logic [SIZE_DATA-1:0] f;
  logic [SH-1:0]        shamt;

  assign a     = i_rs_value;
  assign b     = i_rt_value;
  assign shamt = b[SH-1:0];

  always_comb begin
    f = '0;
    unique case (1'b1)
      (i_alu_op == 4'd0): f = a + b;
      (i_alu_op == 4'd1): f = a - b;
      (i_alu_op == 4'd2): f = a & b;
      (i_alu_op == 4'd3): f = a | b;
      (i_alu_op == 4'd4): f = a ^ b;
      (i_alu_op == 4'd5): f = ~(a | b);
      (i_alu_op == 4'd6): f = SIZE_DATA'($signed(a) >>> shamt);
      (i_alu_op == 4'd7): f = a >> shamt;
      (i_alu_op == 4'd8):
        f = {{(SIZE_DATA-1){1'b0}}, ($signed(a) < $signed(b))};
      default: f = '0;
    endcase
  end

`ifdef EX_MUL_EN
  localparam int CW = $clog2(SIZE_DATA + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state;
  logic [SIZE_DATA-1:0] mcand;
  logic [SIZE_DATA-1:0] mplier;
  logic [SIZE_DATA-1:0] acc;
  logic [SIZE_DATA-1:0] acc_nxt;
  logic [SIZE_DATA-1:0] mrd;
  logic [CW-1:0]        count;
  logic                 is_mul;
  logic                 last;

  assign is_mul  = (i_alu_op == 4'd9);
  assign last    = (count == CW'(1));
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Release the stall on the final iteration so ID/EX loads on that edge
  assign o_stall = !i_reset &&
                   (((state == IDLE) && i_valid && is_mul) ||
                    ((state == MUL) && !last));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_rd     <= '0;
      o_zero   <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      mrd      <= '0;
      count    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid && is_mul) begin
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            mrd     <= i_rd;
            count   <= CW'(SIZE_DATA);
            o_valid <= 1'b0;
            state   <= MUL;
          end else if (i_valid) begin
            o_result <= f;
            o_rd     <= i_rd;
            o_zero   <= (f == '0);
            o_valid  <= 1'b1;
          end else begin
            o_valid <= 1'b0;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (last) begin
            o_result <= acc_nxt;
            o_rd     <= mrd;
            o_zero   <= (acc_nxt == '0);
            o_valid  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign o_stall = 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_rd     <= '0;
      o_zero   <= 1'b0;
    end else if (i_valid) begin
      o_result <= f;
      o_rd     <= i_rd;
      o_zero   <= (f == '0);
      o_valid  <= 1'b1;
    end else begin
      o_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; upstream latch is modelled as holding
// its instruction while o_stall is high.
module tb_ex_stage;

`ifdef EX_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic       i_clk;
  logic       i_reset;
  logic       i_valid;
  logic [3:0] i_alu_op;
  logic [7:0] i_rs_value;
  logic [7:0] i_rt_value;
  logic [7:0] i_rd;
  logic       o_valid;
  logic [7:0] o_result;
  logic [7:0] o_rd;
  logic       o_zero;
  logic       o_stall;

  ex_stage #(.SIZE_DATA(8)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_alu_op   (i_alu_op),
    .i_rs_value (i_rs_value),
    .i_rt_value (i_rt_value),
    .i_rd       (i_rd),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_rd       (o_rd),
    .o_zero     (o_zero),
    .o_stall    (o_stall)
  );

  typedef struct {
    logic [7:0] res;
    logic [7:0] rd;
    logic       z;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented result must match the head of the queue,
  // in the cycle right after the edge that accepted its instruction.
  always @(negedge i_clk) begin
    if (o_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: cyc %0d res %0h rd %0h",
                 cyc, o_result, o_rd);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || o_result !== e.res || o_rd !== e.rd ||
            o_zero !== e.z) begin
          errors++;
          $display("FAIL result: got cyc %0d res %0h rd %0h z %0b expected cyc %0d res %0h rd %0h z %0b",
                   cyc, o_result, o_rd, o_zero, e.cyc, e.res, e.rd, e.z);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_valid: got none at cyc %0d expected res %0h rd %0h",
               cyc, e.res, e.rd);
    end
  end

  // Drive one instruction and hold it until the stage accepts it.
  task automatic issue(input string name, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] rd, input logic [7:0] res,
                       input int exp_stall);
    int  n;
    bit  st;
    bit  done;
    exp_t e;
    n = 0;
    done = 0;
    i_valid = 1'b1;
    i_alu_op = op;
    i_rs_value = a;
    i_rt_value = b;
    i_rd = rd;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge i_clk);
      st = o_stall;
      if (st) n++;
      @(posedge i_clk);
      #1;
      if (!st) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got stall stuck expected release", name);
    end else begin
      e.res = res;
      e.rd = rd;
      e.z = (res == 8'h00);
      e.cyc = cyc;
      q.push_back(e);
    end
    chk({name, "_stall_cycles"}, n, exp_stall);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    @(negedge i_clk);
    chk({name, "_valid"}, o_valid, 0);
    chk({name, "_result"}, o_result, 0);
    chk({name, "_rd"}, o_rd, 0);
    chk({name, "_zero"}, o_zero, 0);
    chk({name, "_stall"}, o_stall, 0);
  endtask

  localparam int MS = MUL_ON ? 8 : 0;

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_alu_op = 4'd0;
    i_rs_value = 8'h00;
    i_rt_value = 8'h00;
    i_rd = 8'h00;
    repeat (3) @(posedge i_clk);
    chk_reset_outputs("reset");
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    // A MUL opcode without i_valid must not stall
    i_alu_op = 4'd9;
    @(negedge i_clk);
    chk("idle_mul_novalid_stall", o_stall, 0);
    @(posedge i_clk);
    #1;

    issue("add", 4'd0, 8'h7F, 8'h01, 8'd3, 8'h80, 0);
    issue("sub", 4'd1, 8'h05, 8'h05, 8'd4, 8'h00, 0);
    issue("slt", 4'd8, 8'hFF, 8'h01, 8'd5, 8'h01, 0);
    issue("sra", 4'd6, 8'h80, 8'h03, 8'd6, 8'hF0, 0);
    issue("sra_mask", 4'd6, 8'h80, 8'h0B, 8'd6, 8'hF0, 0);
    issue("srl", 4'd7, 8'h80, 8'h03, 8'd8, 8'h10, 0);
    issue("and", 4'd2, 8'hF0, 8'h3C, 8'd9, 8'h30, 0);
    issue("or", 4'd3, 8'hF0, 8'h0F, 8'd10, 8'hFF, 0);
    issue("xor", 4'd4, 8'hFF, 8'h0F, 8'd11, 8'hF0, 0);
    issue("nor", 4'd5, 8'h00, 8'h00, 8'd12, 8'hFF, 0);
    issue("slt_false", 4'd8, 8'h01, 8'hFF, 8'd13, 8'h00, 0);
    issue("sub_wrap", 4'd1, 8'h00, 8'h01, 8'd14, 8'hFF, 0);
    issue("add_wrap", 4'd0, 8'hFF, 8'h01, 8'd15, 8'h00, 0);
    issue("undef", 4'd12, 8'h12, 8'h34, 8'd16, 8'h00, 0);
    idle(2);

    issue("mul", 4'd9, 8'h0D, 8'h0B, 8'd7, MUL_ON ? 8'h8F : 8'h00, MS);
    issue("add_after_mul", 4'd0, 8'h02, 8'h03, 8'd9, 8'h05, 0);
    issue("mul_ff", 4'd9, 8'hFF, 8'hFF, 8'd1, MUL_ON ? 8'h01 : 8'h00, MS);
    issue("mul_zero", 4'd9, 8'h10, 8'h10, 8'd2, 8'h00, MS);
    issue("mul_small", 4'd9, 8'h03, 8'h04, 8'd5, MUL_ON ? 8'h0C : 8'h00, MS);
    idle(2);

`ifdef EX_MUL_EN
    // Abort a MUL in its 4th stalled cycle
    i_valid = 1'b1;
    i_alu_op = 4'd9;
    i_rs_value = 8'h0D;
    i_rt_value = 8'h0B;
    i_rd = 8'd7;
    repeat (3) begin
      @(negedge i_clk);
      chk("mid_mul_stall", o_stall, 1);
      @(posedge i_clk);
      #1;
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("stall_during_reset", o_stall, 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    chk_reset_outputs("mid_mul_reset");
`else
    issue("pre_reset_add", 4'd0, 8'h03, 8'h04, 8'd11, 8'h07, 0);
    idle(1);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk_reset_outputs("late_reset");
`endif
    @(posedge i_clk);
    #1;
    issue("add_after_reset", 4'd0, 8'h01, 8'h01, 8'd2, 8'h02, 0);
    idle(4);

    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
